chu_gpo_pulse: RTL
==================

// Module: chu_gpo_pulse
// PURPOSE
//  MMIO slot core driving a W-bit general-purpose output port; successor to the basic GPO slot.
//  Adds atomic set/clear/toggle writes, readback, and a timed one-shot pulse engine.
//  The pulse engine asserts selected bits for a programmable number of clk cycles, then self-clears.
//  Sits in a bus slot; dout goes to LEDs/strobes at the top level.
// PARAMETERS
//  W   8   output port width, 1..32
//  CW  16  pulse-length counter width, 1..32
// PORTS
//  clk      in   1   system clock
//  reset    in   1   asynchronous, active-high reset
//  cs       in   1   slot select
//  read     in   1   read strobe (no side effects; accepted, unused)
//  write    in   1   write strobe; a write is accepted when cs && write
//  addr     in   5   register address
//  wr_data  in   32  write data
//  rd_data  out  32  read data, combinational mux on addr; unused upper bits 0
//  dout     out  W   external output = buf_reg | pls_reg
// BEHAVIOUR
//  Reset: buf_reg=0, pls_reg=0, len_reg=0, cnt=0, state=IDLE, done=0; dout=0.
//  Register map (only wr_data[W-1:0] is used for bit operations; unmapped writes ignored, reads 0):
//   0 DATA  W: buf<=d        R: buf_reg
//   1 SET   W: buf<=buf|d    R: buf_reg
//   2 CLR   W: buf<=buf&~d   R: buf_reg
//   3 TGL   W: buf<=buf^d    R: buf_reg
//   4 LEN   W: len_reg<=wr_data[CW-1:0]   R: len_reg
//   5 PULSE W: trigger pulse on bits d    R: pls_reg
//   6 CTRL  W: bit0=abort, bit1=clear done   R: {30'b0, done, busy}
//   7 PIN   W: ignored                     R: dout
//  All register updates take effect at the clk edge that samples the write; dout changes 1 cycle later.
//  Pulse FSM, states IDLE / ACTIVE; busy = (state==ACTIVE):
//   IDLE + PULSE write, len_reg!=0, d!=0 -> pls_reg<=d, cnt<=len_reg, ACTIVE.
//   IDLE + PULSE write with len_reg==0 or d==0 -> ignored, stay IDLE.
//   ACTIVE, no event: cnt<=cnt-1 while cnt>1; when cnt==1 -> pls_reg<=0, done<=1, IDLE.
//   ACTIVE + PULSE write (len_reg!=0): retrigger: pls_reg<=pls_reg|d, cnt<=len_reg; takes priority over expiry.
//   ACTIVE + PULSE write with len_reg==0: ignored; countdown continues.
//   ACTIVE + CTRL abort -> pls_reg<=0, cnt<=0, IDLE; done is not set. Abort outranks a retrigger in the same cycle only if both are sampled (impossible on a single write, since addr differs).
//  Pulse width: bits are high in dout for exactly len_reg cycles after the write edge (len=1 gives a 1-cycle strobe).
//  done: sticky; set only on natural expiry; cleared by CTRL bit1. Set beats clear if both occur in the same cycle.
//  LEN write while ACTIVE: affects only the next trigger or retrigger; the current count is unchanged.
//  buf_reg writes never affect pls_reg or the FSM. A bit high in buf_reg stays high in dout through pulse expiry (OR).
//  Reset mid-pulse: everything returns to its reset values immediately (asynchronous); dout=0.
//  cnt width is CW; len_reg max 2^CW-1; no wrap-around, because decrement stops at 1.
// TESTING
//  Reset with random prior state -> dout=0, rd addr6=0, rd addr4=0.
//  W DATA=0xA5; SET 0x0F; CLR 0x81; TGL 0xFF -> dout sequence 0xA5, 0xAF, 0x2E, 0xD1; rd addr0 matches.
//  LEN=3, PULSE 0x01 with buf=0 -> dout[0] high exactly 3 cycles, busy=1 during, then done=1, busy=0.
//  LEN=5, PULSE 0x01; after 3 cycles PULSE 0x02 -> bits 0 and 1 both drop exactly 5 cycles after the 2nd write.
//  LEN=10, PULSE 0xF0; abort after 2 cycles -> dout=0 next cycle, done stays 0. LEN=0 PULSE -> no change.
//  Assert reset during ACTIVE with LEN=100 -> dout=0 asynchronously; after release, busy=0 and a PULSE with len=0 does nothing.

Source files
------------

// File: rtl/chu_gpo_pulse.sv
// MMIO general-purpose output slot with atomic set/clear/toggle writes and a
// self-clearing timed pulse engine; dout is the OR of the static and pulse bits.
module chu_gpo_pulse #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] dout,
    output logic         dbg_state
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    localparam logic [4:0] A_DATA  = 5'd0;
    localparam logic [4:0] A_SET   = 5'd1;
    localparam logic [4:0] A_CLR   = 5'd2;
    localparam logic [4:0] A_TGL   = 5'd3;
    localparam logic [4:0] A_LEN   = 5'd4;
    localparam logic [4:0] A_PULSE = 5'd5;
    localparam logic [4:0] A_CTRL  = 5'd6;
    localparam logic [4:0] A_PIN   = 5'd7;

    state_t        state_q;
    logic [W-1:0]  buf_q, buf_d;
    logic [W-1:0]  pls_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    logic          wr_en;
    logic [W-1:0]  wr_bits;
    logic          pulse_wr;
    logic          ctrl_wr;
    logic          abort;
    logic          busy;
    logic          unused_ok;

    // Bus protocol: there is no ready/stall; a write is accepted in exactly the
    // cycle where cs && write are high at the rising clk edge. Reads are
    // side-effect free and rd_data is a pure combinational function of addr.
    assign wr_en    = cs & write;
    assign wr_bits  = wr_data[W-1:0];
    assign pulse_wr = wr_en && (addr == A_PULSE);
    assign ctrl_wr  = wr_en && (addr == A_CTRL);
    assign abort    = ctrl_wr && wr_data[0];
    assign busy     = (state_q == S_ACTIVE);

    assign unused_ok = ^{read, wr_data};

    always_comb begin
        buf_d = buf_q;
        if (wr_en) begin
            case (addr)
                A_DATA:  buf_d = wr_bits;
                A_SET:   buf_d = buf_q | wr_bits;
                A_CLR:   buf_d = buf_q & ~wr_bits;
                A_TGL:   buf_d = buf_q ^ wr_bits;
                default: buf_d = buf_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            pls_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            buf_q <= buf_d;
            if (wr_en && (addr == A_LEN)) begin
                len_q <= wr_data[CW-1:0];
            end
            if (ctrl_wr && wr_data[1]) begin
                done_q <= 1'b0;
            end
            // Expiry below assigns done_q after the clear, so a set wins.
            case (state_q)
                S_IDLE: begin
                    if (pulse_wr && (len_q != '0) && (wr_bits != '0)) begin
                        pls_q   <= wr_bits;
                        cnt_q   <= len_q;
                        state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (abort) begin
                        pls_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (pulse_wr && (len_q != '0)) begin
                        pls_q <= pls_q | wr_bits;
                        cnt_q <= len_q;
                    end else if (cnt_q > CW'(1)) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        pls_q   <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout      = buf_q | pls_q;
    assign dbg_state = state_q;

    always_comb begin
        rd_data = '0;
        case (addr)
            A_DATA, A_SET, A_CLR, A_TGL: rd_data[W-1:0]  = buf_q;
            A_LEN:                       rd_data[CW-1:0] = len_q;
            A_PULSE:                     rd_data[W-1:0]  = pls_q;
            A_CTRL:                      rd_data[1:0]    = {done_q, busy};
            A_PIN:                       rd_data[W-1:0]  = dout;
            default:                     rd_data         = '0;
        endcase
    end

endmodule
